// File: rtl/tetromino_fetch.sv
// tetromino_fetch: read-side client of the tetromino shape/colour block RAM.
// A piece request (id + rotation) triggers one RAM read on port 0. The word
// is captured a cycle later and the 4x4 shape mask is rotated clockwise one
// quarter turn per cycle. Shape, colour and error flag are then returned on
// a valid/ready response channel.
// Optional feature: define TETRO_CACHE_EN to keep a one-entry cache of the
// last fetched word. A cache hit skips the RAM access, and cache_inv clears
// the cached entry.

module tetromino_fetch #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 4,
    parameter int NUM_PIECES = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_id,
    input  logic [1:0]        req_rot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_shape,
    output logic [7:0]        rsp_color,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    output logic [DWIDTH-1:0] d0,
    input  logic [DWIDTH-1:0] q0,
    input  logic              cache_inv
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] ROT   = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [31:0] NUM_P = NUM_PIECES;

    logic [2:0]        state;
    logic [AWIDTH-1:0] id_reg;
    logic [1:0]        rot_reg;
    logic [1:0]        cnt;
    logic [15:0]       shape_reg;
    logic [7:0]        color_reg;
    logic              err_reg;
    logic              accept;
    logic              id_in_range;
    logic              cache_hit;
    logic [23:0]       cache_data;

    // One clockwise quarter turn: new[r][c] = old[3-c][r], bit = row*4+col
    function automatic logic [15:0] rot_cw(input logic [15:0] s);
        logic [15:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r*4+c] = s[(3-c)*4+r];
            end
        end
        return o;
    endfunction

    assign req_ready   = (state == IDLE) && rst_n;
    assign accept      = req_valid && req_ready;
    assign id_in_range = ({{(32-AWIDTH){1'b0}}, req_id} < NUM_P);

    assign rsp_valid = (state == RESP);
    assign rsp_shape = shape_reg;
    assign rsp_color = color_reg;
    assign rsp_err   = err_reg;

    assign ce0   = (state == FETCH);
    assign addr0 = (state == FETCH) ? id_reg : '0;
    assign we0   = 1'b0;
    assign d0    = '0;

`ifdef TETRO_CACHE_EN
    logic              cache_valid;
    logic [AWIDTH-1:0] cache_id;
    logic [23:0]       cache_word;
    logic              unused_bits;

    assign cache_hit   = cache_valid && (cache_id == req_id);
    assign cache_data  = cache_word;
    assign unused_bits = ^q0;

    // Cache entry: filled on every RAM latch, cleared by reset or cache_inv (inv wins)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
        end else if (cache_inv) begin
            cache_valid <= 1'b0;
        end else if (state == LATCH) begin
            cache_valid <= 1'b1;
            cache_id    <= id_reg;
            cache_word  <= q0[23:0];
        end
    end
`else
    logic unused_bits;

    assign cache_hit   = 1'b0;
    assign cache_data  = '0;
    assign unused_bits = ^{cache_inv, q0};
`endif

    // Request/response sequencer: fetch, latch, rotate, then hold the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            id_reg    <= '0;
            rot_reg   <= '0;
            cnt       <= '0;
            shape_reg <= '0;
            color_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_reg  <= req_id;
                        rot_reg <= req_rot;
                        if (!id_in_range) begin
                            shape_reg <= '0;
                            color_reg <= '0;
                            err_reg   <= 1'b1;
                            state     <= RESP;
                        end else if (cache_hit) begin
                            shape_reg <= cache_data[15:0];
                            color_reg <= cache_data[23:16];
                            err_reg   <= 1'b0;
                            cnt       <= req_rot;
                            state     <= (req_rot == 2'd0) ? RESP : ROT;
                        end else begin
                            err_reg <= 1'b0;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shape_reg <= q0[15:0];
                    color_reg <= q0[23:16];
                    cnt       <= rot_reg;
                    state     <= (rot_reg == 2'd0) ? RESP : ROT;
                end
                ROT: begin
                    shape_reg <= rot_cw(shape_reg);
                    cnt       <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetromino_fetch.sv
// Self-checking bench for tetromino_fetch: directed requests push expected
// responses into a queue that an independent monitor pops and compares.
// Expected latencies follow a small cache model when TETRO_CACHE_EN is set.

module tb_tetromino_fetch;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_id;
    logic [1:0]        req_rot;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_shape;
    logic [7:0]        rsp_color;
    logic              rsp_err;
    logic [AWIDTH-1:0] addr0;
    logic              ce0;
    logic              we0;
    logic [DWIDTH-1:0] d0;
    logic [DWIDTH-1:0] q0;
    logic              cache_inv;

    typedef struct {
        logic [15:0] shape;
        logic [7:0]  color;
        logic        err;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ce0_count = 0;
    int   exp_addr = 0;
    int   exp_ce0_cyc = 0;
    bit   seen_first = 0;
    bit   mc_valid = 0;
    int   mc_id = 0;

    logic [DWIDTH-1:0] ram [16];

    tetromino_fetch #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NUM_PIECES(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_rot(req_rot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_shape(rsp_shape), .rsp_color(rsp_color), .rsp_err(rsp_err),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
        .cache_inv(cache_inv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM model
    always @(posedge clk) if (ce0) q0 <= ram[addr0];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Response monitor: compare every valid cycle to the queue head, pop on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_first = 0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, required no response");
            end else begin
                checkOutput("rsp_shape", rsp_shape, exp_q[0].shape);
                checkOutput("rsp_color", rsp_color, exp_q[0].color);
                checkOutput("rsp_err", rsp_err, exp_q[0].err);
                if (!seen_first) checkOutput("rsp_latency", cyc, exp_q[0].at_cyc);
                seen_first = 1;
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    seen_first = 0;
                end
            end
        end
    end

    // RAM port monitor: each ce0 pulse must target the expected address in C1
    always @(negedge clk) begin
        if (rst_n && ce0) begin
            ce0_count++;
            checkOutput("ce0_addr", addr0, exp_addr);
            checkOutput("ce0_cycle", cyc, exp_ce0_cyc);
            checkOutput("we0_d0", {31'd0, we0} | d0, 0);
        end
    end

    task automatic applyStimulus(input int id, input int rot, input logic [15:0] shp,
                                 input logic [7:0] col, input bit stall);
        int   c0, lat, base, waited;
        bit   err, hit;
        exp_t e;
        err = (id >= 7);
        hit = 0;
`ifdef TETRO_CACHE_EN
        hit = !err && mc_valid && (mc_id == id);
`endif
        lat  = err ? 1 : (hit ? 1 + rot : 3 + rot);
        base = ce0_count;
        @(negedge clk);
        rsp_ready = !stall;
        req_id    = id[AWIDTH-1:0];
        req_rot   = rot[1:0];
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL req_ready_timeout: got req_ready=0, required 1");
            req_valid = 1'b0;
            return;
        end
        c0          = cyc;
        exp_addr    = id;
        exp_ce0_cyc = c0 + 1;
        e.shape  = err ? 16'h0 : shp;
        e.color  = err ? 8'h0 : col;
        e.err    = err;
        e.at_cyc = c0 + lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (stall) begin
            waited = 0;
            while (!rsp_valid && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checkOutput("stall_req_ready", req_ready, 0);
                checkOutput("stall_rsp_valid", rsp_valid, 1);
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL rsp_timeout: got no handshake, required response id=%0d", id);
            exp_q.delete();
        end
        @(negedge clk);
        checkOutput("req_ready_after_rsp", req_ready, 1);
        checkOutput("ce0_pulses", ce0_count - base, (err || hit) ? 0 : 1);
`ifdef TETRO_CACHE_EN
        if (!err && !hit) begin
            mc_valid = 1;
            mc_id    = id;
        end
`endif
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        ram[0] = 32'h001F_00F0;
        ram[3] = 32'hFFC3_8001;
        ram[5] = 32'h0007_0033;
        ram[6] = 32'h00E7_0660;
        q0        = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_id    = '0;
        req_rot   = '0;
        rsp_ready = 1'b1;
        cache_inv = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_shape", rsp_shape, 0);
        checkOutput("reset_rsp_color", rsp_color, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_ce0", ce0, 0);
        checkOutput("reset_addr0", addr0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_req_ready", req_ready, 1);

        applyStimulus(0, 0, 16'h00F0, 8'h1F, 0);
        applyStimulus(0, 1, 16'h4444, 8'h1F, 0);
        applyStimulus(0, 2, 16'h0F00, 8'h1F, 0);
        applyStimulus(9, 0, 16'h0000, 8'h00, 0);
        applyStimulus(7, 2, 16'h0000, 8'h00, 0);
        applyStimulus(6, 2, 16'h0660, 8'hE7, 0);
        applyStimulus(3, 1, 16'h1008, 8'hC3, 1);

        // Reset while rotating a rot=3 request: no response may follow
        @(negedge clk);
        req_id    = 4'd5;
        req_rot   = 2'd3;
        req_valid = 1'b1;
        c0          = cyc;
        exp_addr    = 5;
        exp_ce0_cyc = c0 + 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (cyc < c0 + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        mc_valid = 0;
        @(negedge clk);
        checkOutput("after_rst_req_ready", req_ready, 1);
        checkOutput("after_rst_rsp_valid", rsp_valid, 0);
        applyStimulus(0, 3, 16'h2222, 8'h1F, 0);

        applyStimulus(0, 0, 16'h00F0, 8'h1F, 0);
        @(negedge clk);
        cache_inv = 1'b1;
        @(negedge clk);
        cache_inv = 1'b0;
        mc_valid  = 0;
        applyStimulus(0, 0, 16'h00F0, 8'h1F, 0);
        applyStimulus(0, 1, 16'h4444, 8'h1F, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tetromino_fetch.md
Name: tetromino_fetch

Overview:
- Read-side client of the tetromino shape/colour block RAM.
- Accepts a piece request (piece id + rotation) from game_logic_core and issues a single read on the RAM's port-0 interface.
- Captures the word one cycle later, rotates the 4x4 shape mask clockwise the requested number of times (one quarter turn per cycle), and returns shape + colour over a valid/ready response channel.
- The RAM contents are written separately through the AXI4-lite side.

Parameters:
- DWIDTH, 32, RAM word width; must be >= 24.
- AWIDTH, 4, RAM address width.
- NUM_PIECES, 7, number of valid piece ids (0..NUM_PIECES-1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_id  in  AWIDTH  piece id; also used as the RAM address.
- req_rot  in  2  clockwise quarter turns, 0..3.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_shape  out  16  4x4 mask; bit index = row*4+col, row 0 is the top.
- rsp_color  out  8  RGB332 colour.
- rsp_err  out  1  req_id >= NUM_PIECES.
- addr0  out  AWIDTH  RAM port-0 address.
- ce0  out  1  RAM port-0 enable.
- we0  out  1  tied to 0.
- d0  out  DWIDTH  tied to 0.
- q0  in  DWIDTH  RAM port-0 read data, registered inside the RAM.
- cache_inv  in  1  invalidate pulse for the cached word; ignored unless TETRO_CACHE_EN is defined.

Behaviour:
- RAM word format: [15:0] rotation-0 shape, [23:16] colour, [DWIDTH-1:24] ignored.
- Reset (rst_n=0 at a clock edge): state IDLE; req_ready=0 during reset and 1 from the first cycle after; rsp_valid=0, rsp_shape=0, rsp_color=0, rsp_err=0, ce0=0, addr0=0.
- Reset mid-operation aborts immediately. No response is produced.
- States: IDLE, FETCH, LATCH, ROT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready (cycle C0), register id and rot.
  - If id >= NUM_PIECES: go to RESP with shape=0, color=0, err=1, and no RAM access.
  - Otherwise go to FETCH.
- FETCH (C1): ce0=1, addr0=id for exactly one cycle. Go to LATCH.
- LATCH (C2):
  - Capture q0[15:0] into a shape register and q0[23:16] into a colour register.
  - If rot==0, go to RESP; otherwise go to ROT with a counter = rot.
- ROT:
  - Each cycle, apply new[r][c] = old[3-c][r] and decrement the counter.
  - Go to RESP when the counter reaches 0.
- RESP:
  - rsp_valid=1; outputs stable until rsp_valid&&rsp_ready.
  - On handshake, go to IDLE; req_ready returns to 1 in the following cycle.
- req_ready=0 in every state except IDLE. Back-to-back requests therefore have at least one idle cycle between responses.
- Latency:
  - Valid id: rsp_valid first asserted in cycle C3+rot (rot=0 gives C3; rot=3 gives C6).
  - Invalid id: rsp_valid in C1.
- ce0 is asserted for only the single FETCH cycle per request. we0 and d0 are constant 0.
- rsp_ready held 0 indefinitely: the block stalls in RESP with outputs unchanged, and no further RAM reads occur.

Optional Feature:
- Macro: TETRO_CACHE_EN.
- Defined:
  - Keep one cached entry: valid bit, id, raw 24-bit word. Reset clears the valid bit.
  - On accept with a valid id equal to the cached id and the valid bit set, skip FETCH/LATCH. Load the shape/colour from the cache and go to ROT or RESP in C1 (rsp_valid at C1+rot). ce0 stays 0.
  - On a miss, LATCH also updates the cache.
  - cache_inv=1 in any cycle clears the valid bit. If cache_inv=1 coincides with a LATCH cache update, the invalidate wins.
- Undefined: cache_inv is ignored and every valid request performs FETCH/LATCH.

Test Plan:
- RAM[0]=0x001F00F0; request id=0, rot=0 -> single ce0 pulse with addr0=0 in C1; rsp_valid in C3 with shape=0x00F0, color=0x1F, err=0.
- Same RAM; request id=0, rot=1 -> rsp_valid in C4 with shape=0x4444, color=0x1F. Request rot=2 -> shape=0x0F00 in C5.
- Request id=9 (NUM_PIECES=7) -> no ce0; rsp_valid in C1 with shape=0, color=0, err=1.
- Response with rsp_ready=0 for 10 cycles, then 1 -> rsp_* stable throughout; req_ready=0 throughout; one handshake; req_ready=1 in the following cycle.
- rst_n=0 asserted during ROT of a rot=3 request -> next cycle rsp_valid=0, state IDLE; a subsequent request completes normally.
- TETRO_CACHE_EN defined:
  - Two consecutive id=0 rot=0 requests -> the second has no ce0 and rsp_valid in C1.
  - cache_inv pulse, then a third request -> ce0 pulse again, response in C3.
